// File: rtl/muldiv_unit.sv
// Iterative M-extension multiply/divide: radix-2 shift-add multiply and restoring divide.
// One op in flight; XLEN+1 (or WLEN+1 for W ops) cycles to done_o, 1 cycle on the fast path.
module muldiv_unit #(
   parameter  int XLEN = 64,
   localparam int WLEN = XLEN / 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] srca_i,
   input  logic [XLEN-1:0] srcb_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [2:0] OP_MUL  = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd1;
   localparam logic [2:0] OP_DIVU = 3'd2;
   localparam logic [2:0] OP_REM  = 3'd3;
   localparam logic [2:0] OP_REMU = 3'd4;
   localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [WLEN-1:0] MIN_W = {1'b1, {(WLEN-1){1'b0}}};
   localparam logic [CW-1:0] LAST_X = CW'(XLEN - 1);
   localparam logic [CW-1:0] LAST_W = CW'(WLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
      return {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]};
   endfunction

   function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] x);
      return {{(XLEN-WLEN){1'b0}}, x[WLEN-1:0]};
   endfunction

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic              r_w;
   logic              r_is_div;
   logic              r_is_rem;
   logic              r_neg_q;
   logic              r_neg_r;
   logic [XLEN-1:0]   r_a;
   logic [XLEN-1:0]   r_b;
   logic [XLEN-1:0]   r_acc;
   logic [XLEN-1:0]   r_result;

   // Request decode and operand conditioning at accept.
   logic              w_in_w, w_in_signed, w_in_div, w_in_rem, w_in_rsvd;
   logic [XLEN-1:0]   w_a_ext, w_b_ext, w_a_abs, w_b_abs;
   logic              w_a_neg, w_b_neg, w_b_zero, w_ovf, w_fast;
   logic [XLEN-1:0]   w_fast_res;

   assign w_in_w      = op_i[3];
   assign w_in_signed = (op_i[2:0] == OP_DIV) || (op_i[2:0] == OP_REM);
   assign w_in_rem    = (op_i[2:0] == OP_REM) || (op_i[2:0] == OP_REMU);
   assign w_in_div    = (op_i[2:0] != OP_MUL) && (op_i[2:0] <= OP_REMU);
   assign w_in_rsvd   = (op_i[2:0] > OP_REMU);

   assign w_a_ext  = !w_in_w ? srca_i : (w_in_signed ? sext_w(srca_i) : zext_w(srca_i));
   assign w_b_ext  = !w_in_w ? srcb_i : (w_in_signed ? sext_w(srcb_i) : zext_w(srcb_i));
   assign w_a_neg  = w_in_signed && w_a_ext[XLEN-1];
   assign w_b_neg  = w_in_signed && w_b_ext[XLEN-1];
   assign w_a_abs  = w_a_neg ? -w_a_ext : w_a_ext;
   assign w_b_abs  = w_b_neg ? -w_b_ext : w_b_ext;
   assign w_b_zero = (w_b_ext == '0);
   assign w_ovf    = w_in_signed && (&w_b_ext) &&
                     (w_in_w ? (srca_i[WLEN-1:0] == MIN_W) : (srca_i == MIN_X));
   assign w_fast   = w_in_rsvd || (w_in_div && w_b_zero) || w_ovf;

   always_comb begin
      w_fast_res = '0;
      if (w_in_rsvd)
         w_fast_res = '0;
      else if (w_b_zero)
         w_fast_res = w_in_rem ? (w_in_w ? sext_w(srca_i) : srca_i) : '1;
      else if (w_ovf)
         w_fast_res = w_in_rem ? '0 : (w_in_w ? sext_w(srca_i) : srca_i);
   end

   // One iteration of each datapath; the divide shifts quotient bits into r_a as it drains.
   logic              w_top, w_qbit, w_last;
   logic [XLEN:0]     w_rsh, w_diff;
   logic [XLEN-1:0]   w_acc_div, w_a_div, w_acc_mul, w_q, w_r, w_raw, w_fin;

   assign w_top     = r_w ? r_a[WLEN-1] : r_a[XLEN-1];
   assign w_rsh     = {r_acc, w_top};
   assign w_diff    = w_rsh - {1'b0, r_b};
   assign w_qbit    = ~w_diff[XLEN];
   assign w_acc_div = w_qbit ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
   assign w_a_div   = {r_a[XLEN-2:0], w_qbit};
   assign w_acc_mul = r_acc + (r_b[0] ? r_a : '0);
   assign w_last    = (r_cnt == (r_w ? LAST_W : LAST_X));

   assign w_q   = r_neg_q ? -w_a_div : w_a_div;
   assign w_r   = r_neg_r ? -w_acc_div : w_acc_div;
   assign w_raw = !r_is_div ? w_acc_mul : (r_is_rem ? w_r : w_q);
   assign w_fin = r_w ? sext_w(w_raw) : w_raw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_w      <= 1'b0;
         r_is_div <= 1'b0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else if (flush_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (valid_i) begin
               r_cnt    <= '0;
               r_w      <= w_in_w;
               r_is_div <= w_in_div;
               r_is_rem <= w_in_rem;
               r_neg_q  <= w_a_neg ^ w_b_neg;
               r_neg_r  <= w_a_neg;
               r_a      <= w_a_abs;
               r_b      <= w_b_abs;
               r_acc    <= '0;
               if (w_fast) begin
                  r_result <= w_fast_res;
                  r_state  <= S_DONE;
               end else begin
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_is_div) begin
                  r_acc <= w_acc_div;
                  r_a   <= w_a_div;
               end else begin
                  r_acc <= w_acc_mul;
                  r_a   <= {r_a[XLEN-2:0], 1'b0};
                  r_b   <= {1'b0, r_b[XLEN-1:1]};
               end
               if (w_last) begin
                  r_result <= w_fin;
                  r_cnt    <= '0;
                  r_state  <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready_o  = (r_state == S_IDLE);
   assign busy_o   = (r_state != S_IDLE);
   assign done_o   = (r_state == S_DONE);
   assign result_o = r_result;

endmodule
